// File: rtl/fetch_arbiter_pkg.sv
// Shared types and default sizing for the fetch arbiter and its round-robin picker.
package fetch_arbiter_pkg;

  localparam int NUM_REQ_DEF        = 3;
  localparam int BUF_SEL_W_DEF      = 4;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap-around.
module rr_pick
  import fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic found_s;
  int   idx_s;

  // Walk the requesters in priority order; each bit wins only if nothing earlier did.
  always_comb begin
    winner  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s         = (int'(rr_ptr) + i) % NUM_REQ;
      winner[idx_s] = req[idx_s] & ~found_s;
      found_s       = found_s | req[idx_s];
    end
    valid = found_s;
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Arbitrates several requesters onto one fetch engine; owns grant, fetch kick-off and timeout recovery.
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int BUF_SEL_W      = BUF_SEL_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BUF_SEL_W-1:0]   req_buf_sel,
  input  logic [NUM_REQ-1:0]             req_tiles_ctrl,
  input  logic [NUM_REQ-1:0]             req_dbuf,
  output logic [NUM_REQ-1:0]             grant,
  output logic [ID_W-1:0]                grant_id,
  output logic [NUM_REQ-1:0]             done,
  output logic                           done_err,
  output logic                           start_fetch,
  output logic                           reset_addr_counter,
  output logic [BUF_SEL_W-1:0]           Buffer_Select,
  output logic                           Tiles_Control,
  output logic                           Double_buffering,
  input  logic                           fetch_done,
  input  logic                           fetch_busy,
  output logic                           arb_busy,
  output logic                           timeout_err,
  input  logic                           err_clr
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = idx | (oh[i] ? ID_W'(i) : {ID_W{1'b0}});
    end
    return idx;
  endfunction

  arb_state_t           state_r;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]     tmo_cnt_r;
  logic [NUM_REQ-1:0]   win_s;
  logic                 win_valid_s;
  logic [ID_W-1:0]      win_id_s;
  logic [BUF_SEL_W-1:0] win_sel_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .winner (win_s),
    .valid  (win_valid_s)
  );

  assign win_id_s  = onehot_to_idx(win_s);
  assign win_sel_s = req_buf_sel[int'(win_id_s)*BUF_SEL_W +: BUF_SEL_W];

  // Arbitration FSM; every output is a register so downstream sees glitch-free controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_IDLE;
      rr_ptr_r           <= '0;
      tmo_cnt_r          <= '0;
      grant              <= '0;
      grant_id           <= '0;
      done               <= '0;
      done_err           <= 1'b0;
      start_fetch        <= 1'b0;
      reset_addr_counter <= 1'b0;
      Buffer_Select      <= '0;
      Tiles_Control      <= 1'b0;
      Double_buffering   <= 1'b0;
      arb_busy           <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      // A timeout set later in this block overrides a simultaneous clear.
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s && !fetch_busy) begin
            state_r          <= ST_GRANT;
            grant            <= win_s;
            grant_id         <= win_id_s;
            Buffer_Select    <= win_sel_s;
            Tiles_Control    <= req_tiles_ctrl[win_id_s];
            Double_buffering <= req_dbuf[win_id_s];
            arb_busy         <= 1'b1;
          end
        end
        ST_GRANT: begin
          state_r     <= ST_START;
          start_fetch <= 1'b1;
        end
        ST_START: begin
          state_r     <= ST_WAIT;
          start_fetch <= 1'b0;
          tmo_cnt_r   <= '0;
        end
        ST_WAIT: begin
          if (fetch_done) begin
            state_r  <= ST_RELEASE;
            done     <= grant;
            done_err <= 1'b0;
          end else if (tmo_cnt_r == CNT_LAST) begin
            state_r            <= ST_RELEASE;
            done               <= grant;
            done_err           <= 1'b1;
            reset_addr_counter <= 1'b1;
            timeout_err        <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          state_r            <= ST_IDLE;
          done               <= '0;
          done_err           <= 1'b0;
          reset_addr_counter <= 1'b0;
          grant              <= '0;
          grant_id           <= '0;
          arb_busy           <= 1'b0;
          tmo_cnt_r          <= '0;
          rr_ptr_r           <= (grant_id == ID_LAST) ? {ID_W{1'b0}} : grant_id + ID_W'(1);
        end
        default: begin
          state_r     <= ST_IDLE;
          grant       <= '0;
          grant_id    <= '0;
          done        <= '0;
          start_fetch <= 1'b0;
          arb_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Self-checking bench for fetch_arbiter: directed vector table, hand sequences and random transactions.
module tb_fetch_arbiter;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] req_buf_sel;
  logic [2:0]  req_tiles_ctrl;
  logic [2:0]  req_dbuf;
  logic [2:0]  grant;
  logic [1:0]  grant_id;
  logic [2:0]  done;
  logic        done_err;
  logic        start_fetch;
  logic        reset_addr_counter;
  logic [3:0]  Buffer_Select;
  logic        Tiles_Control;
  logic        Double_buffering;
  logic        fetch_done;
  logic        fetch_busy;
  logic        arb_busy;
  logic        timeout_err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;
  bit tmo_m    = 1'b0;

  fetch_arbiter #(
    .NUM_REQ        (3),
    .BUF_SEL_W      (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req                (req),
    .req_buf_sel        (req_buf_sel),
    .req_tiles_ctrl     (req_tiles_ctrl),
    .req_dbuf           (req_dbuf),
    .grant              (grant),
    .grant_id           (grant_id),
    .done               (done),
    .done_err           (done_err),
    .start_fetch        (start_fetch),
    .reset_addr_counter (reset_addr_counter),
    .Buffer_Select      (Buffer_Select),
    .Tiles_Control      (Tiles_Control),
    .Double_buffering   (Double_buffering),
    .fetch_done         (fetch_done),
    .fetch_busy         (fetch_busy),
    .arb_busy           (arb_busy),
    .timeout_err        (timeout_err),
    .err_clr            (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  m;
    logic [11:0] sels;
    logic [2:0]  tc;
    logic [2:0]  db;
    int          d;
    bit          drop;
    bit          clr;
    bit          clr_late;
    bit          hold;
    logic [2:0]  eg;
    bit          eerr;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Round-robin rule: scan upward from ptr, wrapping modulo 3.
  function automatic logic [2:0] pick(input logic [2:0] m, input int p);
    logic [2:0] one;
    one = 3'b001;
    for (int i = 0; i < 3; i++) begin
      if (m[(p + i) % 3]) return one << ((p + i) % 3);
    end
    return 3'b000;
  endfunction

  function automatic int idx_of(input logic [2:0] g);
    if (g[0]) return 0;
    if (g[1]) return 1;
    return 2;
  endfunction

  // One full transaction starting from an IDLE negedge; expectations come from eg/eerr and d.
  task automatic run_txn(input logic [2:0] m, input logic [11:0] sels, input logic [2:0] tc,
                         input logic [2:0] db, input int d, input bit drop, input bit clr,
                         input bit clr_late, input bit hold, input logic [2:0] eg, input bit eerr);
    int         gi;
    int         kend;
    logic [3:0] exp_sel;
    gi      = idx_of(eg);
    kend    = eerr ? TMO - 1 : d;
    exp_sel = sels[gi*4 +: 4];
    req            = m;
    req_buf_sel    = sels;
    req_tiles_ctrl = tc;
    req_dbuf       = db;
    err_clr        = clr;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    if (clr) tmo_m = 1'b0;
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_id", 32'(grant_id), 32'(gi));
    chk("buf_sel", 32'(Buffer_Select), 32'(exp_sel));
    chk("tiles", 32'(Tiles_Control), 32'(tc[gi]));
    chk("dbuf", 32'(Double_buffering), 32'(db[gi]));
    chk("start_early", 32'(start_fetch), 32'd0);
    chk("busy_grant", 32'(arb_busy), 32'd1);
    chk("tmo_at_grant", 32'(timeout_err), 32'(tmo_m));
    if (drop) req = 3'b000;
    req_buf_sel    = 12'($urandom);
    req_tiles_ctrl = 3'($urandom);
    req_dbuf       = 3'($urandom);
    @(posedge clk); @(negedge clk);
    chk("start", 32'(start_fetch), 32'd1);
    chk("grant_hold", 32'(grant), 32'(eg));
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) chk("start_pulse", 32'(start_fetch), 32'd0);
      chk("done_wait", 32'(done), 32'd0);
      fetch_done = (k == d);
      err_clr    = clr_late && (k == kend);
    end
    @(posedge clk); @(negedge clk);
    fetch_done = 1'b0;
    err_clr    = 1'b0;
    tmo_m      = eerr ? 1'b1 : (clr_late ? 1'b0 : tmo_m);
    chk("done", 32'(done), 32'(eg));
    chk("done_err", 32'(done_err), 32'(eerr));
    chk("rst_addr", 32'(reset_addr_counter), 32'(eerr));
    chk("tmo_err", 32'(timeout_err), 32'(tmo_m));
    chk("buf_sel_stable", 32'(Buffer_Select), 32'(exp_sel));
    chk("grant_release", 32'(grant), 32'(eg));
    ptr_m = (gi + 1) % 3;
    if (!hold) req = 3'b000;
    @(posedge clk); @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(arb_busy), 32'd0);
    chk("idle_rst_addr", 32'(reset_addr_counter), 32'd0);
  endtask

  initial begin
    //          m       sels     tc      db     d  drop clr  late hold  eg     eerr
    vt[0] = '{3'b111, 12'h123, 3'b101, 3'b011, 5,  1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0};
    vt[1] = '{3'b111, 12'h456, 3'b010, 3'b101, 3,  1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0};
    vt[2] = '{3'b111, 12'h789, 3'b100, 3'b010, 7,  1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0};
    vt[3] = '{3'b111, 12'hABC, 3'b001, 3'b110, 2,  1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
    vt[4] = '{3'b010, 12'h953, 3'b010, 3'b000, 10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vt[5] = '{3'b101, 12'hE21, 3'b100, 3'b100, 25, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1};
    vt[6] = '{3'b110, 12'h3C7, 3'b000, 3'b010, 19, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vt[7] = '{3'b011, 12'h5A9, 3'b001, 3'b000, 0,  1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0};
    vt[8] = '{3'b001, 12'h00D, 3'b000, 3'b001, 30, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1};
    vt[9] = '{3'b100, 12'hB00, 3'b100, 3'b000, 4,  1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0};

    rst = 1'b1; req = 3'b000; req_buf_sel = 12'h000; req_tiles_ctrl = 3'b000; req_dbuf = 3'b000;
    fetch_done = 1'b0; fetch_busy = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(start_fetch), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_buf_sel", 32'(Buffer_Select), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(vt[i].m, vt[i].sels, vt[i].tc, vt[i].db, vt[i].d, vt[i].drop, vt[i].clr,
              vt[i].clr_late, vt[i].hold, vt[i].eg, vt[i].eerr);
    end

    // Engine busy holds off arbitration; a stray fetch_done in IDLE must not complete anything.
    fetch_busy = 1'b1; req = 3'b001; fetch_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      fetch_done = 1'b0;
      chk("busy_hold_grant", 32'(grant), 32'd0);
      chk("stray_done", 32'(done), 32'd0);
      chk("busy_hold_arb", 32'(arb_busy), 32'd0);
    end
    fetch_busy = 1'b0;
    run_txn(3'b001, 12'h007, 3'b001, 3'b000, 6, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  m;
      int          d;
      m = 3'($urandom_range(1, 7));
      d = int'($urandom_range(0, 24));
      run_txn(m, 12'($urandom), 3'($urandom), 3'($urandom), d, 1'($urandom), 1'($urandom),
              1'($urandom), 1'b0, pick(m, ptr_m), d >= TMO);
    end

    // Leave rr_ptr at 1 with a sticky error, then reset in the middle of a wait.
    run_txn(3'b001, 12'h00F, 3'b001, 3'b001, 25, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1);
    req = 3'b010;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_start", 32'(start_fetch), 32'd0);
    chk("mid_rst_rst_addr", 32'(reset_addr_counter), 32'd0);
    chk("mid_rst_busy", 32'(arb_busy), 32'd0);
    chk("mid_rst_tmo", 32'(timeout_err), 32'd0);
    chk("mid_rst_buf_sel", 32'(Buffer_Select), 32'd0);
    chk("mid_rst_tiles", 32'(Tiles_Control), 32'd0);
    chk("mid_rst_dbuf", 32'(Double_buffering), 32'd0);
    rst = 1'b0; req = 3'b000;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_rst_addr", 32'(reset_addr_counter), 32'd0);
    end
    ptr_m = 0;
    tmo_m = 1'b0;
    run_txn(3'b101, 12'h321, 3'b000, 3'b000, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
